// File: rtl/cv32e40s_pkg.sv
// Shared types for the register-file write-port arbiter and its secondary-write buffer.
package cv32e40s_pkg;

    typedef logic [4:0] rf_addr_t;

    typedef struct packed {
        rf_addr_t    waddr;
        logic [31:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        rf_wr_t wr;
        logic   valid;
    } rf_wr_buf_t;

    typedef enum logic [1:0] {
        SelNone,
        SelHead,
        SelPrimary,
        SelBypass
    } rf_sel_e;

    function automatic logic [31:0] addr_onehot(input rf_addr_t addr);
        logic [31:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cv32e40s_rf_wport_arbiter_if.sv
// Write-port arbiter bus: WB primary write, secondary handshake, RF write port and status.
interface cv32e40s_rf_wport_arbiter_if;

    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_halt_o;
    logic        sec_valid_i;
    logic        sec_ready_o;
    logic [4:0]  sec_waddr_i;
    logic [31:0] sec_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_mask_o;
    logic [15:0] stall_cnt_o;

    modport slave (
        input  wb_we_i,
        input  wb_waddr_i,
        input  wb_wdata_i,
        output wb_halt_o,
        input  sec_valid_i,
        output sec_ready_o,
        input  sec_waddr_i,
        input  sec_wdata_i,
        output rf_we_o,
        output rf_waddr_o,
        output rf_wdata_o,
        output pend_mask_o,
        output stall_cnt_o
    );

    modport master (
        output wb_we_i,
        output wb_waddr_i,
        output wb_wdata_i,
        input  wb_halt_o,
        output sec_valid_i,
        input  sec_ready_o,
        output sec_waddr_i,
        output sec_wdata_i,
        input  rf_we_o,
        input  rf_waddr_o,
        input  rf_wdata_o,
        input  pend_mask_o,
        input  stall_cnt_o
    );

endinterface

// File: rtl/cv32e40s_rf_wr_fifo.sv
// Secondary-write buffer: in-order FIFO with per-entry address-match kill and pending-write mask.
module cv32e40s_rf_wr_fifo
    import cv32e40s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  rf_wr_t      i_push_data,
    input  logic        i_pop,
    input  logic        i_kill,
    input  rf_addr_t    i_kill_addr,
    output rf_wr_buf_t  o_head,
    output logic        o_empty,
    output logic        o_not_full,
    output logic [31:0] o_pend_mask
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    rf_wr_buf_t      r_mem   [FIFO_DEPTH];
    rf_wr_buf_t      w_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] r_rptr;
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] w_rptr_d;
    logic [PtrW-1:0] w_wptr_d;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] w_count_d;
    logic            w_do_pop;
    logic            w_do_push;

    assign o_empty    = (r_count == '0);
    assign o_not_full = (r_count < DepthCnt);
    assign o_head     = r_mem[r_rptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && o_not_full;

    // Vacated slots get valid cleared so the pending mask can OR every slot blindly.
    always_comb begin
        w_mem_d = r_mem;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (i_kill && (r_mem[i].wr.waddr == i_kill_addr)) begin
                w_mem_d[i].valid = 1'b0;
            end
        end
        if (w_do_pop) begin
            w_mem_d[r_rptr].valid = 1'b0;
        end
        if (w_do_push) begin
            w_mem_d[r_wptr].wr    = i_push_data;
            w_mem_d[r_wptr].valid = !(i_kill && (i_push_data.waddr == i_kill_addr));
        end
    end

    always_comb begin
        w_rptr_d  = r_rptr;
        w_wptr_d  = r_wptr;
        w_count_d = r_count;
        if (w_do_pop) begin
            w_rptr_d = (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
        end
        if (w_do_push) begin
            w_wptr_d = (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
        end
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count - CntW'(1);
        end
    end

    always_comb begin
        o_pend_mask = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (r_mem[i].valid) begin
                o_pend_mask = o_pend_mask | addr_onehot(r_mem[i].wr.waddr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rptr  <= w_rptr_d;
            r_wptr  <= w_wptr_d;
            r_count <= w_count_d;
            r_mem   <= w_mem_d;
        end
    end

endmodule

// File: rtl/cv32e40s_rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, secondary writes bypass or buffer, and
// starvation forces a one-cycle WB halt. CV32E40S_RF_ARB_STATS_EN adds the forced-halt counter.
module cv32e40s_rf_wport_arbiter
    import cv32e40s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                        clk,
    input logic                        rst,
    cv32e40s_rf_wport_arbiter_if.slave bus
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    rf_wr_t             w_sec_wr;
    rf_wr_buf_t         w_head;
    logic               w_empty;
    logic               w_not_full;
    logic               w_sec_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_kill;
    rf_sel_e            w_sel;
    logic               w_we;
    logic [4:0]         w_waddr;
    logic [31:0]        w_wdata;
    logic [StarveW-1:0] r_starve;
    logic [StarveW-1:0] w_starve_d;
    logic               r_halt;
    logic               w_halt_d;

    assign w_sec_wr.waddr = bus.sec_waddr_i;
    assign w_sec_wr.wdata = bus.sec_wdata_i;
    assign w_sec_hs       = bus.sec_valid_i && w_not_full;

    cv32e40s_rf_wr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_data(w_sec_wr),
        .i_pop      (w_pop),
        .i_kill     (w_kill),
        .i_kill_addr(bus.wb_waddr_i),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_not_full (w_not_full),
        .o_pend_mask(bus.pend_mask_o)
    );

    // Any accepted secondary write that is not bypassed goes into the buffer.
    always_comb begin
        w_sel  = SelNone;
        w_pop  = 1'b0;
        w_push = 1'b0;
        w_kill = 1'b0;
        if (r_halt) begin
            w_sel  = SelHead;
            w_pop  = !w_empty;
            w_push = w_sec_hs;
        end else if (bus.wb_we_i) begin
            w_sel  = SelPrimary;
            w_push = w_sec_hs;
            w_kill = 1'b1;
        end else if (!w_empty) begin
            w_sel  = SelHead;
            w_pop  = 1'b1;
            w_push = w_sec_hs;
        end else if (w_sec_hs) begin
            w_sel = SelBypass;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (w_sel)
            SelHead: begin
                w_we    = !w_empty && w_head.valid;
                w_waddr = w_head.wr.waddr;
                w_wdata = w_head.wr.wdata;
            end
            SelPrimary: begin
                w_we    = 1'b1;
                w_waddr = bus.wb_waddr_i;
                w_wdata = bus.wb_wdata_i;
            end
            SelBypass: begin
                w_we    = 1'b1;
                w_waddr = bus.sec_waddr_i;
                w_wdata = bus.sec_wdata_i;
            end
            default: ;
        endcase
    end

    // x0 is never written; the reset cycle emits nothing so discarded entries stay discarded.
    assign bus.rf_we_o     = w_we && (w_waddr != '0) && !rst;
    assign bus.rf_waddr_o  = w_waddr;
    assign bus.rf_wdata_o  = w_wdata;
    assign bus.sec_ready_o = w_not_full;
    assign bus.wb_halt_o   = r_halt;

    always_comb begin
        w_starve_d = r_starve;
        if (w_empty || w_pop) begin
            w_starve_d = '0;
        end else if (r_starve != StarveMax) begin
            w_starve_d = r_starve + StarveW'(1);
        end
        w_halt_d = (w_starve_d == StarveMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_halt   <= 1'b0;
        end else begin
            r_starve <= w_starve_d;
            r_halt   <= w_halt_d;
        end
    end

`ifdef CV32E40S_RF_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] w_stall_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        if (r_halt && (r_stall_cnt != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_cnt_d;
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`else
    assign bus.stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cv32e40s_rf_wport_arbiter.sv
// Bench for cv32e40s_rf_wport_arbiter: every emitted RF write is checked against a queue of
// expected writes; each scenario task checks status outputs inline.
module tb_cv32e40s_rf_wport_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

`ifdef CV32E40S_RF_ARB_STATS_EN
    localparam logic [15:0] ExpStall = 16'd1;
`else
    localparam logic [15:0] ExpStall = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40s_rf_wport_arbiter_if bus ();

    cv32e40s_rf_wport_arbiter #(
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.rf_we_o === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write_unexpected: got x%0d=%h, required no write",
                         bus.rf_waddr_o, bus.rf_wdata_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.rf_waddr_o !== mon_e.addr || bus.rf_wdata_o !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL rf_write: got x%0d=%h, required x%0d=%h",
                             bus.rf_waddr_o, bus.rf_wdata_o, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.wb_we_i     = 1'b0;
        bus.wb_waddr_i  = '0;
        bus.wb_wdata_i  = '0;
        bus.sec_valid_i = 1'b0;
        bus.sec_waddr_i = '0;
        bus.sec_wdata_i = '0;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i    = 1'b1;
        bus.wb_waddr_i = a;
        bus.wb_wdata_i = d;
    endtask

    task automatic drive_sec(input logic [4:0] a, input logic [31:0] d);
        bus.sec_valid_i = 1'b1;
        bus.sec_waddr_i = a;
        bus.sec_wdata_i = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        sample();
        n_tests++;
        if (bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_rf_we: got %b, required 0", bus.rf_we_o);
        end
        n_tests++;
        if (bus.wb_halt_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_halt: got %b, required 0", bus.wb_halt_o);
        end
        n_tests++;
        if (bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_pend: got %h, required 0", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.sec_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.sec_ready_o);
        end
        n_tests++;
        if (bus.stall_cnt_o !== 16'h0) begin
            n_fail++; $display("FAIL reset_stall: got %h, required 0", bus.stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_primary();
        drive_wb(5'd5, 32'hA5A5_0001);
        expect_wr(5'd5, 32'hA5A5_0001);
        sample();
        n_tests++;
        if (bus.rf_we_o !== 1'b1) begin
            n_fail++; $display("FAIL primary_we: got %b, required 1", bus.rf_we_o);
        end
        n_tests++;
        if (bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL primary_pend: got %h, required 0", bus.pend_mask_o);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_bypass();
        drive_sec(5'd7, 32'h0000_1234);
        expect_wr(5'd7, 32'h0000_1234);
        sample();
        n_tests++;
        if (bus.rf_we_o !== 1'b1) begin
            n_fail++; $display("FAIL bypass_we: got %b, required 1", bus.rf_we_o);
        end
        next_cycle();
        idle_inputs();
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL bypass_pend: got %h, required 0", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.sec_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bypass_ready: got %b, required 1", bus.sec_ready_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_sec(5'(16 + i), 32'hC0DE_0000 + 32'(i));
            expect_wr(5'(16 + i), 32'hC0DE_0000 + 32'(i));
            sample();
            n_tests++;
            if (bus.rf_we_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_we[%0d]: got %b, required 1", i, bus.rf_we_o);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_buffer_drain();
        drive_wb(5'd10, 32'h1000_0001);
        drive_sec(5'd3, 32'h0000_0D03);
        expect_wr(5'd10, 32'h1000_0001);
        next_cycle();
        drive_wb(5'd11, 32'h1000_0002);
        drive_sec(5'd4, 32'h0000_0D04);
        expect_wr(5'd11, 32'h1000_0002);
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0000_0008) begin
            n_fail++; $display("FAIL drain_pend_one: got %h, required 00000008", bus.pend_mask_o);
        end
        next_cycle();
        // Full buffer: this offer must wait a cycle even though x3 drains now.
        bus.wb_we_i = 1'b0;
        drive_sec(5'd8, 32'h0000_0D08);
        expect_wr(5'd3, 32'h0000_0D03);
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0000_0018) begin
            n_fail++; $display("FAIL drain_pend_two: got %h, required 00000018", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.sec_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_ready_full: got %b, required 0", bus.sec_ready_o);
        end
        next_cycle();
        expect_wr(5'd4, 32'h0000_0D04);
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0000_0010) begin
            n_fail++; $display("FAIL drain_pend_x4: got %h, required 00000010", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.sec_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL drain_ready: got %b, required 1", bus.sec_ready_o);
        end
        next_cycle();
        idle_inputs();
        expect_wr(5'd8, 32'h0000_0D08);
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0000_0100) begin
            n_fail++; $display("FAIL drain_pend_x8: got %h, required 00000100", bus.pend_mask_o);
        end
        next_cycle();
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0 || bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got pend=%h we=%b, required pend=0 we=0",
                               bus.pend_mask_o, bus.rf_we_o);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        drive_wb(5'd20, 32'h5000_0000);
        drive_sec(5'd9, 32'h0000_0D09);
        expect_wr(5'd20, 32'h5000_0000);
        next_cycle();
        bus.sec_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_wb(5'(20 + i), 32'h5000_0000 + 32'(i));
            expect_wr(5'(20 + i), 32'h5000_0000 + 32'(i));
            sample();
            n_tests++;
            if (bus.wb_halt_o !== 1'b0) begin
                n_fail++; $display("FAIL starve_halt_early[%0d]: got %b, required 0", i, bus.wb_halt_o);
            end
            if (i == 1) begin
                n_tests++;
                if (bus.pend_mask_o !== 32'h0000_0200) begin
                    n_fail++; $display("FAIL starve_pend: got %h, required 00000200", bus.pend_mask_o);
                end
            end
            next_cycle();
        end
        drive_wb(5'd25, 32'h5000_0005);
        expect_wr(5'd9, 32'h0000_0D09);
        sample();
        n_tests++;
        if (bus.wb_halt_o !== 1'b1) begin
            n_fail++; $display("FAIL starve_halt: got %b, required 1", bus.wb_halt_o);
        end
        next_cycle();
        expect_wr(5'd25, 32'h5000_0005);
        sample();
        n_tests++;
        if (bus.wb_halt_o !== 1'b0) begin
            n_fail++; $display("FAIL starve_halt_release: got %b, required 0", bus.wb_halt_o);
        end
        n_tests++;
        if (bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL starve_pend_clear: got %h, required 0", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.stall_cnt_o !== ExpStall) begin
            n_fail++; $display("FAIL starve_stall_cnt: got %h, required %h", bus.stall_cnt_o, ExpStall);
        end
        next_cycle();
        idle_inputs();
        sample();
        n_tests++;
        if (bus.wb_halt_o !== 1'b0 || bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL starve_after: got halt=%b we=%b, required 0 0",
                               bus.wb_halt_o, bus.rf_we_o);
        end
        next_cycle();
    endtask

    task automatic test_waw_kill();
        drive_wb(5'd12, 32'h0000_0C0C);
        drive_sec(5'd6, 32'h0000_1111);
        expect_wr(5'd12, 32'h0000_0C0C);
        next_cycle();
        bus.sec_valid_i = 1'b0;
        drive_wb(5'd6, 32'h0000_BEEF);
        expect_wr(5'd6, 32'h0000_BEEF);
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0000_0040) begin
            n_fail++; $display("FAIL waw_pend_before: got %h, required 00000040", bus.pend_mask_o);
        end
        next_cycle();
        idle_inputs();
        sample();
        n_tests++;
        if (bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL waw_pend_after: got %h, required 0", bus.pend_mask_o);
        end
        n_tests++;
        if (bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL waw_killed_pop: got %b, required 0", bus.rf_we_o);
        end
        next_cycle();
        sample();
        n_tests++;
        if (bus.sec_ready_o !== 1'b1 || bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL waw_drained: got ready=%b we=%b, required 1 0",
                               bus.sec_ready_o, bus.rf_we_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        drive_wb(5'd26, 32'h6000_0000);
        drive_sec(5'd13, 32'h0000_0E13);
        expect_wr(5'd26, 32'h6000_0000);
        next_cycle();
        drive_wb(5'd27, 32'h6000_0001);
        drive_sec(5'd14, 32'h0000_0E14);
        expect_wr(5'd27, 32'h6000_0001);
        next_cycle();
        bus.sec_valid_i = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            drive_wb(5'(26 + i), 32'h6000_0000 + 32'(i));
            expect_wr(5'(26 + i), 32'h6000_0000 + 32'(i));
            if (i == 4) begin
                sample();
                n_tests++;
                if (bus.sec_ready_o !== 1'b0 || bus.pend_mask_o !== 32'h0000_6000) begin
                    n_fail++; $display("FAIL midop_full: got ready=%b pend=%h, required 0 00006000",
                                       bus.sec_ready_o, bus.pend_mask_o);
                end
            end
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        sample();
        n_tests++;
        if (bus.wb_halt_o !== 1'b1) begin
            n_fail++; $display("FAIL midop_halt_pending: got %b, required 1", bus.wb_halt_o);
        end
        n_tests++;
        if (bus.rf_we_o !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst_we: got %b, required 0", bus.rf_we_o);
        end
        next_cycle();
        rst = 1'b0;
        sample();
        n_tests++;
        if (bus.rf_we_o !== 1'b0 || bus.pend_mask_o !== 32'h0) begin
            n_fail++; $display("FAIL midop_after_we_pend: got we=%b pend=%h, required 0 0",
                               bus.rf_we_o, bus.pend_mask_o);
        end
        n_tests++;
        if (bus.sec_ready_o !== 1'b1 || bus.wb_halt_o !== 1'b0) begin
            n_fail++; $display("FAIL midop_after_ready_halt: got ready=%b halt=%b, required 1 0",
                               bus.sec_ready_o, bus.wb_halt_o);
        end
        n_tests++;
        if (bus.stall_cnt_o !== 16'h0) begin
            n_fail++; $display("FAIL midop_stall: got %h, required 0", bus.stall_cnt_o);
        end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_primary();
        test_bypass();
        test_back_to_back();
        test_buffer_drain();
        test_starvation();
        test_waw_kill();
        test_reset_midop();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending writes, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
